// File: rtl/merge2_4b_rtl.sv
// Two-input merge: round-robin arbiter feeding a 2-entry {src,msg} FIFO.
// Outputs come only from the head register; a full FIFO still accepts while draining.
module merge2_4b_rtl (
    input  logic       clk,
    input  logic       reset,
    input  logic       in0_val,
    output logic       in0_rdy,
    input  logic [3:0] in0_msg,
    input  logic       in1_val,
    output logic       in1_rdy,
    input  logic [3:0] in1_msg,
    output logic       out_val,
    input  logic       out_rdy,
    output logic [3:0] out_msg,
    output logic       out_src
);

    logic [1:0] count_reg, count_next;
    logic       prio_reg, prio_next;
    logic       space;
    logic       grant0, grant1;
    logic       enq, deq;
    logic [1:0] wr_pos;
    logic [4:0] tail_entry;
    logic [4:0] slot_q [0:1];

    assign space  = (count_reg < 2'd2) || ((count_reg == 2'd2) && out_rdy);

    // Both valid: prio picks; otherwise whichever is valid wins.
    assign grant0 = in0_val && (!in1_val || !prio_reg);
    assign grant1 = in1_val && (!in0_val ||  prio_reg);

    assign in0_rdy = reset && grant0 && space;
    assign in1_rdy = reset && grant1 && space;

    assign enq        = in0_rdy || in1_rdy;
    assign out_val    = (count_reg != 2'd0);
    assign deq        = out_val && out_rdy;
    assign tail_entry = grant1 ? {1'b1, in1_msg} : {1'b0, in0_msg};

    // Slot 0 is always the head; a dequeue shifts slot 1 down before the tail write.
    assign wr_pos     = count_reg - {1'b0, deq};
    assign count_next = count_reg + {1'b0, enq} - {1'b0, deq};
    assign prio_next  = enq ? ~grant1 : prio_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        logic [4:0] entry_reg;
        logic [4:0] entry_next;
        logic [4:0] shifted;

        if (gi == 0) begin : g_head
            assign shifted = deq ? slot_q[1] : entry_reg;
        end else begin : g_tail
            assign shifted = entry_reg;
        end

        always_comb begin
            entry_next = shifted;
            if (enq && (wr_pos == 2'(gi))) begin
                entry_next = tail_entry;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                entry_reg <= 5'd0;
            end else begin
                entry_reg <= entry_next;
            end
        end

        assign slot_q[gi] = entry_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= 2'd0;
            prio_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            prio_reg  <= prio_next;
        end
    end

    assign out_msg = slot_q[0][3:0];
    assign out_src = slot_q[0][4];

endmodule

// File: tb/tb_merge2_4b_rtl.sv
// Bench for merge2_4b_rtl: directed vector table, async-reset sequence,
// then random traffic against a queue-based reference model.
module tb_merge2_4b_rtl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in0_val = 1'b0, in1_val = 1'b0, out_rdy = 1'b0;
    logic [3:0] in0_msg = 4'd0, in1_msg = 4'd0;
    logic       in0_rdy, in1_rdy, out_val, out_src;
    logic [3:0] out_msg;

    int total = 0;
    int bad   = 0;

    merge2_4b_rtl dut (
        .clk     (clk),
        .reset   (reset),
        .in0_val (in0_val),
        .in0_rdy (in0_rdy),
        .in0_msg (in0_msg),
        .in1_val (in1_val),
        .in1_rdy (in1_rdy),
        .in1_msg (in1_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg),
        .out_src (out_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       i0v;
        logic [3:0] i0m;
        logic       i1v;
        logic [3:0] i1m;
        logic       ordy;
        logic       e0r;
        logic       e1r;
        logic       eov;
        logic       chk;
        logic [3:0] emsg;
        logic       esrc;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic i0v, input logic [3:0] i0m,
                                input logic i1v, input logic [3:0] i1m,
                                input logic ordy, input logic e0r, input logic e1r,
                                input logic eov, input logic chk,
                                input logic [3:0] emsg, input logic esrc);
        vec_t v;
        v.i0v = i0v; v.i0m = i0m; v.i1v = i1v; v.i1m = i1m; v.ordy = ordy;
        v.e0r = e0r; v.e1r = e1r; v.eov = eov; v.chk = chk;
        v.emsg = emsg; v.esrc = esrc;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model state: acceptance-ordered queue of {src,msg} plus priority bit.
    logic [4:0] mq [$];
    logic       mprio;

    initial begin
        logic sp, g0, g1;

        tbl[0]  = mk(1'b1, 4'hE, 1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        tbl[1]  = mk(1'b1, 4'hE, 1'b1, 4'h7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hE, 1'b0);
        tbl[2]  = mk(1'b1, 4'hE, 1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h7, 1'b1);
        tbl[3]  = mk(1'b1, 4'hE, 1'b1, 4'h7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hE, 1'b0);
        tbl[4]  = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h7, 1'b1);
        tbl[5]  = mk(1'b1, 4'hA, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        tbl[6]  = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 1'b0);
        tbl[7]  = mk(1'b0, 4'h0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        tbl[8]  = mk(1'b0, 4'h0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1);
        tbl[9]  = mk(1'b0, 4'h0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1);
        tbl[10] = mk(1'b0, 4'h0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1);
        tbl[11] = mk(1'b0, 4'h0, 1'b1, 4'h9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1);
        tbl[12] = mk(1'b1, 4'hC, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1);
        tbl[13] = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 1'b1);
        tbl[14] = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hC, 1'b0);
        tbl[15] = mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);

        // Held in reset with both inputs requesting: nothing may be accepted.
        in0_val = 1'b1; in1_val = 1'b1; out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_val", out_val, 0);
        check("rst_out_msg", out_msg, 0);
        check("rst_out_src", out_src, 0);
        check("rst_in0_rdy", in0_rdy, 0);
        check("rst_in1_rdy", in1_rdy, 0);
        in0_val = 1'b0; in1_val = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            in0_val = tbl[i].i0v; in0_msg = tbl[i].i0m;
            in1_val = tbl[i].i1v; in1_msg = tbl[i].i1m;
            out_rdy = tbl[i].ordy;
            @(negedge clk);
            $display("vec %0d: in0_rdy=%0b in1_rdy=%0b out_val=%0b out_msg=%0h out_src=%0b",
                     i, in0_rdy, in1_rdy, out_val, out_msg, out_src);
            check($sformatf("vec%0d_in0_rdy", i), in0_rdy, tbl[i].e0r);
            check($sformatf("vec%0d_in1_rdy", i), in1_rdy, tbl[i].e1r);
            check($sformatf("vec%0d_out_val", i), out_val, tbl[i].eov);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d_out_msg", i), out_msg, tbl[i].emsg);
                check($sformatf("vec%0d_out_src", i), out_src, tbl[i].esrc);
            end
            @(posedge clk); #1;
        end

        // One entry queued, then reset asserted between edges.
        in0_val = 1'b1; in0_msg = 4'h6; in1_val = 1'b0; out_rdy = 1'b0;
        @(negedge clk);
        check("ar_enq_rdy", in0_rdy, 1);
        @(posedge clk); #1;
        check("ar_count1_val", out_val, 1);
        check("ar_count1_msg", out_msg, 4'h6);
        #1;
        reset = 1'b0;
        in0_val = 1'b1; in0_msg = 4'h2; in1_val = 1'b1; in1_msg = 4'h8; out_rdy = 1'b1;
        #1;
        check("ar_out_val", out_val, 0);
        check("ar_in0_rdy", in0_rdy, 0);
        check("ar_in1_rdy", in1_rdy, 0);
        check("ar_out_msg", out_msg, 0);
        check("ar_out_src", out_src, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ar_post_in0_rdy", in0_rdy, 1);
        check("ar_post_in1_rdy", in1_rdy, 0);
        @(posedge clk); #1;
        $display("async reset: out_val=%0b out_msg=%0h out_src=%0b", out_val, out_msg, out_src);
        check("ar_first_val", out_val, 1);
        check("ar_first_msg", out_msg, 4'h2);
        check("ar_first_src", out_src, 0);

        // Clean restart before random traffic.
        in0_val = 1'b0; in1_val = 1'b0; out_rdy = 1'b0;
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        mq.delete();
        mprio = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                in0_val = 1'b0; in1_val = 1'b0;
                reset = 1'b0;
                #1;
                check("rnd_rst_out_val", out_val, 0);
                mq.delete();
                mprio = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                @(posedge clk); #1;
            end
            in0_val = ($urandom_range(0, 2) != 0);
            in1_val = ($urandom_range(0, 2) != 0);
            in0_msg = 4'($urandom);
            in1_msg = 4'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);

            sp = (mq.size() < 2) || out_rdy;
            g0 = in0_val && (!in1_val || (mprio == 1'b0));
            g1 = in1_val && (!in0_val || (mprio == 1'b1));

            @(negedge clk);
            check("rnd_in0_rdy", in0_rdy, g0 && sp);
            check("rnd_in1_rdy", in1_rdy, g1 && sp);
            check("rnd_out_val", out_val, mq.size() != 0);
            if (mq.size() != 0) begin
                check("rnd_out_msg", out_msg, mq[0][3:0]);
                check("rnd_out_src", out_src, mq[0][4]);
            end

            @(posedge clk);
            if (mq.size() != 0 && out_rdy) begin
                void'(mq.pop_front());
            end
            if ((g0 || g1) && sp) begin
                mq.push_back(g1 ? {1'b1, in1_msg} : {1'b0, in0_msg});
                mprio = ~g1;
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
